// File: rtl/bin_gray_codec_pipe_if.sv
// Handshake bundle for the pipelined binary/Gray codec: upstream word channel
// plus downstream result channel.
interface bin_gray_codec_pipe_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_mode;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_mode, out_data
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_mode, out_data
    );
endinterface

// File: rtl/bin_gray_codec_pipe.sv
// Two-stage pipelined binary<->Gray converter, mode carried per word,
// full throughput with lossless valid/ready backpressure.
module bin_gray_codec_pipe #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bin_gray_codec_pipe_if.slave bus
);
    logic             s1_valid, s2_valid;
    logic             s1_mode, s2_mode;
    logic [WIDTH-1:0] s1_data, s2_data;
    logic [WIDTH-1:0] b2g, g2b, conv;
    logic             s2_adv, in_fire;

    // in_ready looks only at state and out_ready, never at in_valid.
    assign s2_adv       = s1_valid && (!s2_valid || bus.out_ready);
    assign bus.in_ready = !s1_valid || s2_adv;
    assign in_fire      = bus.in_valid && bus.in_ready;

    assign b2g = s1_data ^ (s1_data >> 1);

    // Gray->binary is a running XOR from the MSB down.
    always_comb begin
        logic acc;
        g2b = '0;
        acc = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc    = acc ^ s1_data[i];
            g2b[i] = acc;
        end
    end

    assign conv = s1_mode ? g2b : b2g;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= in_fire || (s1_valid && !s2_adv);
            if (in_fire) begin
                s1_mode <= bus.in_mode;
                s1_data <= bus.in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_mode  <= 1'b0;
            s2_data  <= '0;
        end else begin
            s2_valid <= s2_adv || (s2_valid && !bus.out_ready);
            if (s2_adv) begin
                s2_mode <= s1_mode;
                s2_data <= conv;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_mode  = s2_mode;
    assign bus.out_data  = s2_data;
endmodule
